traffic_lanes: RTL and testbench
================================

TRAFFIC_LANES -- requirements
Module: Traffic_Lanes

Interface
REQ-001 Parameter NUM_LANES, default 4: number of car lanes, legal 1..8.
REQ-002 Parameter TILE_SIZE, default 32: tile edge in pixels; frog is one tile.
REQ-003 Parameter H_VISIBLE_AREA, default 640: visible line width in pixels.
REQ-004 Parameter CAR_W, default 64: car width in pixels.
REQ-005 Parameter STEP_BASE, default 2: pixels moved per lane step at level 0.
REQ-006 Parameter LANE_Y0_TILE, default 9: tile row of lane 0; lane l sits on row LANE_Y0_TILE+l.
REQ-007 Parameter LANE_DIR, default 4'b0101, NUM_LANES bits: bit l set means lane l moves right; clear means left.
REQ-008 Parameter LANE_DIV, default {4'd1,4'd2,4'd3,4'd1}, 4 bits per lane (lane 0 in LSBs): frame ticks per step, legal 1..15.
REQ-009 Parameter LANE_START_X, default 0, 10 bits per lane: X position after reset.
REQ-010 Port i_Clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-011 Port i_Reset, input, 1 bit: asynchronous, active-high reset.
REQ-012 Port i_Frame_Tick, input, 1 bit: one-cycle pulse per video frame.
REQ-013 Port i_Enable, input, 1 bit: high = traffic moves; low = traffic frozen.
REQ-014 Port i_Level, input, 2 bits: speed level added to STEP_BASE.
REQ-015 Port i_Frog_X and i_Frog_Y, input, 10 bits each: frog top-left pixel.
REQ-016 Port o_Car_X, output, 10*NUM_LANES bits: packed car X per lane, lane 0 in LSBs.
REQ-017 Port o_Car_Y, output, 10*NUM_LANES bits: packed car Y per lane.
REQ-018 Port o_Has_Collided, output, 1 bit: frog overlaps any car.
REQ-019 Port o_Hit_Lane, output, 3 bits: index of the lowest-numbered overlapping lane.

Function
REQ-020 Track length TRACK = H_VISIBLE_AREA + CAR_W; every car X SHALL stay within 0..TRACK-1 (X >= H_VISIBLE_AREA is off-screen, display clips).
REQ-021 o_Car_Y lane l SHALL be the constant (LANE_Y0_TILE+l)*TILE_SIZE.
REQ-022 Each lane SHALL own a 4-bit divider counter; on i_Frame_Tick with i_Enable high it increments, and on reaching LANE_DIV[l] it clears and the lane takes one step.
REQ-023 Step size SHALL be STEP_BASE + i_Level, sampled in the cycle the step occurs.
REQ-024 Right-moving step: X+step < TRACK gives X+step; otherwise it gives X+step-TRACK.
REQ-025 Left-moving step: X >= step gives X-step; otherwise it gives X+TRACK-step.
REQ-026 With i_Enable low, positions and divider counters SHALL hold and frame ticks SHALL be ignored.
REQ-027 Position update latency SHALL be 1 cycle after the i_Frame_Tick cycle; all lanes update in the same cycle.
REQ-028 Overlap for lane l: i_Frog_Y == Y_l AND i_Frog_X < X_l+CAR_W AND i_Frog_X+TILE_SIZE > X_l, using 11-bit arithmetic (no wrap).
REQ-029 o_Has_Collided and o_Hit_Lane SHALL be registered: 1-cycle latency from frog inputs or car positions.
REQ-030 o_Has_Collided SHALL be a level, high for every cycle the overlap holds.
REQ-031 On simultaneous overlap with several lanes, o_Hit_Lane SHALL report the lowest index.
REQ-032 o_Hit_Lane SHALL be 0 when o_Has_Collided is low.
REQ-033 Collision evaluation SHALL continue while i_Enable is low.

Reset
REQ-034 While i_Reset is high: car X = LANE_START_X[l], divider counters = 0, o_Has_Collided = 0, o_Hit_Lane = 0.
REQ-035 Reset asserted mid-step SHALL discard the pending step.
REQ-036 The first step after release SHALL follow LANE_DIV[l] qualifying ticks.

Verification (defaults unless stated; TRACK = 704)
REQ-037 Assert i_Reset asynchronously mid-frame -> all o_Car_X equal LANE_START_X immediately, outputs 0.
REQ-038 Lane 0 right, DIV 1, start 700, level 0, two ticks -> X 702, then 0.
REQ-039 Lane 1 left, DIV 1, start 1, level 0, one tick -> X 703; with level 3, start 10 -> X 5.
REQ-040 Lane DIV 3, six ticks -> X changes only after tick 3 and tick 6; ticks with i_Enable low -> no change.
REQ-041 Frog at lane-0 row, X 100: car X 70 -> o_Has_Collided 1, o_Hit_Lane 0 next cycle; car X 132 -> 0.
REQ-042 Frog overlapping lanes 2 and 3 (equal-Y override bench) -> o_Hit_Lane 2.

Source files
------------

// File: rtl/traffic_lanes.sv
// Car lanes for a frogger-style game: per-lane wrapping car motion
// paced by frame ticks, plus a registered frog/car overlap detector.
module traffic_lanes #(
  parameter int                       NUM_LANES      = 4,
  parameter int                       TILE_SIZE      = 32,
  parameter int                       H_VISIBLE_AREA = 640,
  parameter int                       CAR_W          = 64,
  parameter int                       STEP_BASE      = 2,
  parameter int                       LANE_Y0_TILE   = 9,
  parameter logic [NUM_LANES-1:0]     LANE_DIR       = 4'b0101,
  parameter logic [4*NUM_LANES-1:0]   LANE_DIV       = {4'd1, 4'd2, 4'd3, 4'd1},
  parameter logic [10*NUM_LANES-1:0]  LANE_START_X   = '0,
  parameter bit                       LANE_Y_OVR     = 1'b0,
  parameter logic [10*NUM_LANES-1:0]  LANE_Y         = '0
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic                      i_Frame_Tick,
  input  logic                      i_Enable,
  input  logic [1:0]                i_Level,
  input  logic [9:0]                i_Frog_X,
  input  logic [9:0]                i_Frog_Y,
  output logic [10*NUM_LANES-1:0]   o_Car_X,
  output logic [10*NUM_LANES-1:0]   o_Car_Y,
  output logic                      o_Has_Collided,
  output logic [2:0]                o_Hit_Lane
);

  localparam logic [10:0] TRACK11 = 11'(H_VISIBLE_AREA + CAR_W);
  localparam logic [10:0] CARW11  = 11'(CAR_W);
  localparam logic [10:0] TILE11  = 11'(TILE_SIZE);

  logic [10:0]          w_step_sz;
  logic [10:0]          w_frog_x11;
  logic [NUM_LANES-1:0] w_hit;
  logic                 w_col;
  logic [2:0]           w_lane;
  logic                 r_col;
  logic [2:0]           r_lane;

  assign w_step_sz  = 11'(STEP_BASE) + {9'd0, i_Level};
  assign w_frog_x11 = {1'b0, i_Frog_X};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam logic [3:0] DIV = LANE_DIV[4*g +: 4];
    localparam logic [9:0] X0  = LANE_START_X[10*g +: 10];
    localparam logic [9:0] Y0  = 10'((LANE_Y0_TILE + g) * TILE_SIZE);

    logic [9:0]  r_x;
    logic [3:0]  r_div;
    logic [9:0]  w_y;
    logic [10:0] w_x11;
    logic [10:0] w_fwd;
    logic [10:0] w_back;
    logic [9:0]  w_x_nxt;

    assign w_y    = LANE_Y_OVR ? LANE_Y[10*g +: 10] : Y0;
    assign w_x11  = {1'b0, r_x};
    assign w_fwd  = w_x11 + w_step_sz;
    assign w_back = w_x11 + TRACK11 - w_step_sz;

    // Both directions wrap around the off-screen tail of the track.
    assign w_x_nxt = LANE_DIR[g]
      ? ((w_fwd < TRACK11) ? w_fwd[9:0] : 10'(w_fwd - TRACK11))
      : ((w_x11 >= w_step_sz) ? 10'(w_x11 - w_step_sz) : w_back[9:0]);

    always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
        r_x   <= X0;
        r_div <= '0;
      end else if (i_Frame_Tick && i_Enable) begin
        if (r_div + 4'd1 == DIV) begin
          r_div <= '0;
          r_x   <= w_x_nxt;
        end else begin
          r_div <= r_div + 4'd1;
        end
      end
    end

    assign w_hit[g] = (i_Frog_Y == w_y)
                   && (w_frog_x11 < w_x11 + CARW11)
                   && (w_frog_x11 + TILE11 > w_x11);

    assign o_Car_X[10*g +: 10] = r_x;
    assign o_Car_Y[10*g +: 10] = w_y;
  end

  always_comb begin
    w_col  = |w_hit;
    w_lane = '0;
    for (int l = NUM_LANES - 1; l >= 0; l--) begin
      if (w_hit[l]) w_lane = 3'(l);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_col  <= 1'b0;
      r_lane <= '0;
    end else begin
      r_col  <= w_col;
      r_lane <= w_lane;
    end
  end

  assign o_Has_Collided = r_col;
  assign o_Hit_Lane     = r_lane;

endmodule

// File: tb/tb_traffic_lanes.sv
// Directed bench for traffic_lanes: motion/wrap/divider on one instance,
// collision on a second, lowest-lane priority on an equal-Y third.
module tb_traffic_lanes;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        en = 1'b0;
  logic        en_b = 1'b0;
  logic        en_c = 1'b0;
  logic [1:0]  level = 2'd0;
  logic [9:0]  fx = 10'd0;
  logic [9:0]  fy = 10'd0;

  logic [39:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic        a_col, b_col, c_col;
  logic [2:0]  a_hit, b_hit, c_hit;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  traffic_lanes #(
    .LANE_DIV     ({4'd1, 4'd3, 4'd1, 4'd1}),
    .LANE_START_X ({10'd0, 10'd50, 10'd1, 10'd700})
  ) u_a (
    .i_Clk(clk), .i_Reset(rst), .i_Frame_Tick(tick), .i_Enable(en),
    .i_Level(level), .i_Frog_X(fx), .i_Frog_Y(fy),
    .o_Car_X(a_x), .o_Car_Y(a_y), .o_Has_Collided(a_col), .o_Hit_Lane(a_hit)
  );

  traffic_lanes #(
    .LANE_DIV     (16'h1111),
    .LANE_START_X ({10'd0, 10'd0, 10'd0, 10'd70})
  ) u_b (
    .i_Clk(clk), .i_Reset(rst), .i_Frame_Tick(tick), .i_Enable(en_b),
    .i_Level(level), .i_Frog_X(fx), .i_Frog_Y(fy),
    .o_Car_X(b_x), .o_Car_Y(b_y), .o_Has_Collided(b_col), .o_Hit_Lane(b_hit)
  );

  traffic_lanes #(
    .LANE_Y_OVR   (1'b1),
    .LANE_Y       ({4{10'd200}}),
    .LANE_START_X ({10'd90, 10'd80, 10'd500, 10'd600})
  ) u_c (
    .i_Clk(clk), .i_Reset(rst), .i_Frame_Tick(tick), .i_Enable(en_c),
    .i_Level(level), .i_Frog_X(fx), .i_Frog_Y(fy),
    .o_Car_X(c_x), .o_Car_Y(c_y), .o_Has_Collided(c_col), .o_Hit_Lane(c_hit)
  );

  function automatic logic [31:0] ax(input int l);
    return {22'd0, a_x[10*l +: 10]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tck();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_x0", ax(0), 700);
    chk("rst_x1", ax(1), 1);
    chk("rst_x2", ax(2), 50);
    chk("rst_x3", ax(3), 0);
    chk("rst_col", {31'd0, a_col}, 0);
    chk("rst_hit", {29'd0, a_hit}, 0);
    chk("car_y", {22'd0, a_y[39:30]} * 1000000 + {22'd0, a_y[29:20]} * 1000
         + {22'd0, a_y[19:10]} + {22'd0, a_y[9:0]} * 0, 384352320);
    chk("car_y0", {22'd0, a_y[9:0]}, 288);
    rst = 1'b0;

    // six enabled ticks: lane0 right wrap, lane1 left wrap, lane2 /3
    en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tck();
      chk("step_l0", ax(0), (700 + 2 * i) % 704);
      chk("step_l1", ax(1), (705 - 2 * i) % 704);
      chk("div3_l2", ax(2), (i >= 6) ? 54 : (i >= 3) ? 52 : 50);
    end

    // frozen traffic ignores ticks
    en = 1'b0;
    repeat (3) tck();
    chk("frz_l0", ax(0), 8);
    chk("frz_l2", ax(2), 54);

    // divider count is held across a frozen gap
    en = 1'b1;
    repeat (2) tck();
    chk("pre_l2", ax(2), 54);
    en = 1'b0;
    repeat (2) tck();
    en = 1'b1;
    tck();
    chk("hold_div_l2", ax(2), 56);
    chk("hold_l0", ax(0), 14);
    chk("hold_l1", ax(1), 687);

    // level 3 -> step 5
    level = 2'd3;
    tck();
    chk("lvl3_l1", ax(1), 682);
    chk("lvl3_l0", ax(0), 19);

    // asynchronous reset in a tick cycle, before the edge
    @(negedge clk);
    tick = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_x0", ax(0), 700);
    chk("async_x1", ax(1), 1);
    chk("async_x2", ax(2), 50);
    chk("async_x3", ax(3), 0);
    @(negedge clk);
    tick = 1'b0;
    rst = 1'b0;
    #1;
    chk("discard_x0", ax(0), 700);
    chk("discard_x1", ax(1), 1);

    // first steps after release, level 3 wraps both ways
    tck();
    chk("lvl3w_l0", ax(0), 1);
    chk("lvl3w_l1", ax(1), 700);
    chk("lvl3w_l3", ax(3), 699);
    chk("lvl3w_l2", ax(2), 50);
    level = 2'd0;
    tck();
    chk("rel2_l2", ax(2), 50);
    tck();
    chk("rel3_l2", ax(2), 52);

    // collision on lane 0 with registered latency
    en = 1'b0;
    @(negedge clk);
    fx = 10'd100;
    fy = 10'd288;
    #1;
    chk("col_lat", {31'd0, b_col}, 0);
    @(negedge clk);
    chk("col_70", {31'd0, b_col}, 1);
    chk("hit_70", {29'd0, b_hit}, 0);
    en_b = 1'b1;
    repeat (30) tck();
    chk("b_x130", {22'd0, b_x[9:0]}, 130);
    chk("col_130", {31'd0, b_col}, 1);
    tck();
    chk("b_x132", {22'd0, b_x[9:0]}, 132);
    chk("col_lag", {31'd0, b_col}, 1);
    @(negedge clk);
    chk("col_132", {31'd0, b_col}, 0);
    chk("hit_132", {29'd0, b_hit}, 0);

    // detection continues while traffic is frozen
    en_b = 1'b0;
    @(negedge clk);
    fx = 10'd140;
    @(negedge clk);
    chk("col_frozen", {31'd0, b_col}, 1);
    chk("b_x_frozen", {22'd0, b_x[9:0]}, 132);

    // equal-Y lanes: lowest index wins
    fx = 10'd100;
    fy = 10'd200;
    @(negedge clk);
    chk("prio_col", {31'd0, c_col}, 1);
    chk("prio_hit2", {29'd0, c_hit}, 2);
    fx = 10'd150;
    @(negedge clk);
    chk("prio_hit3", {29'd0, c_hit}, 3);
    fy = 10'd201;
    @(negedge clk);
    chk("nohit_col", {31'd0, c_col}, 0);
    chk("nohit_lane", {29'd0, c_hit}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
